// File: rtl/sid_dp_sched_if.sv
// Job-issue bus between the SID scheduler and the shared voice/filter datapath.
//   dp_valid  : scheduler presents a job
//   dp_ready  : datapath accepts the presented job
//   dp_done   : datapath finished the outstanding job (one-cycle pulse)
//   dp_sid    : SID index of the job (0 = SID #1)
//   dp_op     : job code (0..2 voices, 3 filter, 4 output)
//   state_we  : filter state write enable for SID dp_sid
interface sid_dp_sched_if;
    logic       dp_valid;
    logic       dp_ready;
    logic       dp_done;
    logic       dp_sid;
    logic [2:0] dp_op;
    logic       state_we;

    modport master (
        output dp_valid, dp_sid, dp_op, state_we,
        input  dp_ready, dp_done
    );

    modport slave (
        input  dp_valid, dp_sid, dp_op, state_we,
        output dp_ready, dp_done
    );
endinterface

// File: rtl/sid_dp_sched.sv
// Time-multiplexing scheduler for the shared voice/filter datapath.
// On each accepted sample tick it walks SID #1 (and SID #2 when enabled)
// through VOICE1, VOICE2, VOICE3, FILTER, OUTPUT, issuing one job at a time
// and waiting for the datapath completion pulse before the next.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   tick         : sample strobe
//   sid2_en      : include SID #2 jobs (latched when a tick is accepted)
//   clr_overrun  : clears overrun flag and counter (wins over a new overrun)
//   dp           : job-issue bus (master side)
//   busy         : a sample sequence is in progress
//   sample_done  : one-cycle pulse after the last job of a sample completed
//   overrun      : sticky, a tick arrived while busy
//   overrun_cnt  : saturating count of dropped ticks
module sid_dp_sched #(
    parameter int NJOB  = 5,
    parameter int OVR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               sid2_en,
    input  logic               clr_overrun,
    sid_dp_sched_if.master     dp,
    output logic               busy,
    output logic               sample_done,
    output logic               overrun,
    output logic [OVR_W-1:0]   overrun_cnt
);

    localparam logic [2:0] LAST_OP   = 3'(NJOB - 1);
    localparam logic [2:0] FILTER_OP = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               busy_r;
    logic               sid_r;
    logic [2:0]         op_r;
    logic               sid2_r;
    logic               sample_done_r;
    logic               overrun_r;
    logic [OVR_W-1:0]   overrun_cnt_r;
    logic               valid_s;
    logic               we_s;
    logic               job_done_s;
    logic               last_job_s;
    logic               tick_ovr_s;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + OVR_W'(1);
        end
    endfunction

    // Completion of the outstanding job; the last job is OUTPUT of SID #2,
    // or OUTPUT of SID #1 when SID #2 was not enabled at tick time.
    assign job_done_s = (state_r == ST_WAIT) & dp.dp_done;
    assign last_job_s = (op_r == LAST_OP) & (sid_r | ~sid2_r);
    // Any tick seen outside IDLE is dropped, including one coinciding with
    // the final completion (state is still WAIT then).
    assign tick_ovr_s = tick & (state_r != ST_IDLE);

    // State register, plus busy registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // dp_valid is high throughout ISSUE, so ready alone completes the handshake
                if (dp.dp_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (dp.dp_done) begin
                    if (last_job_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        valid_s = 1'b0;
        we_s    = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                valid_s = 1'b1;
            end
            ST_WAIT: begin
                we_s = dp.dp_done & (op_r == FILTER_OP);
            end
            default: begin
                valid_s = 1'b0;
                we_s    = 1'b0;
            end
        endcase
    end

    // Job pointer: reset to (0,0) on an accepted tick, advanced on each completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sid_r  <= 1'b0;
            op_r   <= 3'd0;
            sid2_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && tick) begin
            sid_r  <= 1'b0;
            op_r   <= 3'd0;
            sid2_r <= sid2_en;
        end else if (job_done_s && !last_job_s) begin
            if (op_r == LAST_OP) begin
                sid_r <= 1'b1;
                op_r  <= 3'd0;
            end else begin
                op_r <= op_r + 3'd1;
            end
        end
    end

    // Sample completion pulse, one cycle after the final dp_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_done_r <= 1'b0;
        end else begin
            sample_done_r <= job_done_s & last_job_s;
        end
    end

    // Overrun flag and saturating counter; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r     <= 1'b0;
            overrun_cnt_r <= '0;
        end else if (clr_overrun) begin
            overrun_r     <= 1'b0;
            overrun_cnt_r <= '0;
        end else if (tick_ovr_s) begin
            overrun_r     <= 1'b1;
            overrun_cnt_r <= sat_inc(overrun_cnt_r);
        end
    end

    assign dp.dp_valid = valid_s;
    assign dp.dp_sid   = sid_r;
    assign dp.dp_op    = op_r;
    assign dp.state_we = we_s;
    assign busy        = busy_r;
    assign sample_done = sample_done_r;
    assign overrun     = overrun_r;
    assign overrun_cnt = overrun_cnt_r;

endmodule

// File: tb/tb_sid_dp_sched.sv
// Self-checking bench for sid_dp_sched. A datapath responder serves jobs with
// configurable stalls and latencies; expected jobs are queued at each tick and
// popped on every accepted handshake. Timing, busy, state_we and overrun are
// checked every cycle against a small model.
module tb_sid_dp_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       sid2_en;
    logic       clr_overrun;
    logic       busy;
    logic       sample_done;
    logic       overrun;
    logic [7:0] overrun_cnt;

    sid_dp_sched_if dpif ();

    sid_dp_sched #(.NJOB(5), .OVR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .sid2_en     (sid2_en),
        .clr_overrun (clr_overrun),
        .dp          (dpif.master),
        .busy        (busy),
        .sample_done (sample_done),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic       sid;
        logic [2:0] op;
    } job_t;

    job_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   ovr_flag_m = 1'b0;
    int   ovr_cnt_m  = 0;
    bit   pend_valid = 1'b0;
    int   pend_t     = 0;
    bit   pend_sid2  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic push_jobs(input bit sid2);
        job_t j;
        for (int s = 0; s < (sid2 ? 2 : 1); s++) begin
            for (int o = 0; o < 5; o++) begin
                j.sid = s[0];
                j.op  = o[2:0];
                exp_q.push_back(j);
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_dp_valid", dpif.dp_valid, 0);
        check("rst_dp_sid", dpif.dp_sid, 0);
        check("rst_dp_op", dpif.dp_op, 0);
        check("rst_state_we", dpif.state_we, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_done", sample_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overrun_cnt", overrun_cnt, 0);
    endtask

    // One sample sequence with an emulated datapath; offsets are relative to the tick cycle
    task automatic do_sample(input bit sid2, input int stall_job, input int stall_n,
                             input bit spur, input bit stall_ticks,
                             input int late_job, input int late_n,
                             input int tick_a, input int tick_b, input bit tick_final,
                             input int toggle_off, input int clr_off,
                             input bit chain_next, input bit chain_sid2,
                             input bit abort_filter, input int exp_final);
        bit         from_pend;
        int         t, off, phase, cnt, stall_left, jobs_done, n_jobs, final_cyc;
        bit         tick_d, done_d, clr_d, busy_m, cur_sid;
        logic [2:0] cur_op;
        job_t       j;
        from_pend  = pend_valid;
        pend_valid = 1'b0;
        t          = from_pend ? pend_t : cyc + 1;
        n_jobs     = (from_pend ? pend_sid2 : sid2) ? 10 : 5;
        phase      = 0;
        cnt        = 0;
        jobs_done  = 0;
        final_cyc  = -1;
        cur_sid    = 1'b0;
        cur_op     = 3'd0;
        stall_left = (stall_job == 0) ? stall_n : 0;
        for (int k = 0; k < 2000; k++) begin
            nxt();
            off    = cyc - t;
            tick_d = 1'b0;
            done_d = 1'b0;
            clr_d  = 1'b0;
            if (off == 0 && !from_pend) begin
                tick_d  = 1'b1;
                sid2_en = sid2;
                push_jobs(sid2);
            end
            if (off == toggle_off) sid2_en = ~sid2_en;
            if (off == tick_a || off == tick_b) tick_d = 1'b1;
            if (off == clr_off) begin
                clr_d  = 1'b1;
                tick_d = 1'b1;
            end
            if (phase == 1) begin
                dpif.dp_ready = 1'b0;
                if (cnt == 0) begin
                    done_d = 1'b1;
                    if (jobs_done + 1 == n_jobs) begin
                        final_cyc = cyc;
                        if (tick_final) tick_d = 1'b1;
                    end
                end else begin
                    cnt--;
                end
            end else begin
                dpif.dp_ready = (stall_left == 0);
                if (stall_left > 0 && dpif.dp_valid) begin
                    if (stall_ticks) tick_d = 1'b1;
                    if (spur && stall_left == stall_n) done_d = 1'b1;
                end
            end
            if (final_cyc >= 0 && cyc == final_cyc + 1 && chain_next) begin
                check("q_empty", exp_q.size(), 0);
                tick_d  = 1'b1;
                sid2_en = chain_sid2;
                push_jobs(chain_sid2);
            end
            tick          = tick_d;
            dpif.dp_done  = done_d;
            clr_overrun   = clr_d;

            @(negedge clk);
            busy_m = (off >= 1) && (final_cyc < 0 || cyc <= final_cyc);
            check("busy", busy, busy_m);
            check("sample_done", sample_done, (final_cyc >= 0 && cyc == final_cyc + 1));
            check("state_we", dpif.state_we, (phase == 1 && done_d && cur_op == 3'd3));
            if (phase == 1 && done_d && cur_op == 3'd3) check("we_sid", dpif.dp_sid, cur_sid);
            check("overrun", overrun, ovr_flag_m);
            check("overrun_cnt", overrun_cnt, ovr_cnt_m);
            if (clr_d) begin
                ovr_flag_m = 1'b0;
                ovr_cnt_m  = 0;
            end else if (tick_d && busy_m) begin
                ovr_flag_m = 1'b1;
                if (ovr_cnt_m < 255) ovr_cnt_m++;
            end
            if (phase == 0 && dpif.dp_valid && dpif.dp_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_job", 1, 0);
                end else begin
                    j = exp_q.pop_front();
                    check("job_sid", dpif.dp_sid, j.sid);
                    check("job_op", dpif.dp_op, j.op);
                    cur_sid = j.sid;
                    cur_op  = j.op;
                end
                phase = 1;
                cnt   = (jobs_done == late_job) ? late_n : 0;
                if (abort_filter && cur_op == 3'd3) return;
            end else if (phase == 0 && dpif.dp_valid) begin
                if (exp_q.size() > 0) begin
                    check("stall_sid", dpif.dp_sid, exp_q[0].sid);
                    check("stall_op", dpif.dp_op, exp_q[0].op);
                end
                stall_left--;
            end else if (phase == 1) begin
                check("valid_in_wait", dpif.dp_valid, 0);
                if (done_d) begin
                    jobs_done++;
                    phase      = 0;
                    stall_left = (jobs_done == stall_job) ? stall_n : 0;
                end
            end
            if (final_cyc >= 0 && cyc == final_cyc + 1) begin
                if (!chain_next) check("q_empty", exp_q.size(), 0);
                if (exp_final >= 0) check("final_off", final_cyc - t, exp_final);
                if (chain_next) begin
                    pend_valid = 1'b1;
                    pend_t     = cyc;
                    pend_sid2  = chain_sid2;
                end
                return;
            end
        end
        check("timeout", 0, 1);
    endtask

    initial begin
        rst           = 1'b1;
        tick          = 1'b0;
        sid2_en       = 1'b0;
        clr_overrun   = 1'b0;
        dpif.dp_ready = 1'b0;
        dpif.dp_done  = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        check_reset_outputs();
        nxt();
        rst = 1'b0;
        @(negedge clk);

        // Two SIDs, ideal datapath
        do_sample(1'b1, -1, 0, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 20);
        // One SID, sid2_en raised mid-sequence adds nothing
        do_sample(1'b0, -1, 0, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0, 3, -1, 1'b0, 1'b0, 1'b0, 10);
        // Backpressure on job (0,2) with a spurious done, late done on job (0,4)
        do_sample(1'b1, 2, 3, 1'b1, 1'b0, 4, 7, -1, -1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, -1);
        // Overrun ticks at t+5 and with the final done; new tick in sample_done cycle
        do_sample(1'b1, -1, 0, 1'b0, 1'b0, -1, 0, 5, -1, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0, 20);
        check("ovr_flag_two", overrun, 1);
        check("ovr_cnt_two", overrun_cnt, 2);
        // Chained sample; clear together with an overrun tick
        do_sample(1'b0, -1, 0, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0, -1, 4, 1'b0, 1'b0, 1'b0, 10);
        check("ovr_flag_clr", overrun, 0);
        check("ovr_cnt_clr", overrun_cnt, 0);
        // Saturation: 300 ticks while stalled on the first job
        do_sample(1'b0, 0, 300, 1'b0, 1'b1, -1, 0, -1, -1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, -1);
        check("ovr_cnt_sat", overrun_cnt, 255);
        // Abort in WAIT on the FILTER job via asynchronous reset
        do_sample(1'b1, -1, 0, 1'b0, 1'b0, 0, 2, -1, -1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b1, -1);
        nxt();
        dpif.dp_ready = 1'b0;
        dpif.dp_done  = 1'b0;
        tick          = 1'b0;
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_op", dpif.dp_op, 3);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        nxt();
        rst          = 1'b0;
        dpif.dp_done = 1'b1;
        @(negedge clk);
        check("post_rst_we", dpif.state_we, 0);
        check("post_rst_busy", busy, 0);
        nxt();
        dpif.dp_done = 1'b0;
        exp_q.delete();
        ovr_flag_m = 1'b0;
        ovr_cnt_m  = 0;
        @(negedge clk);
        // Restart from (0,0) after reset
        do_sample(1'b1, -1, 0, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sid_dp_sched.md
# sid_dp_sched

Time-multiplexing scheduler for the shared voice/filter datapath of reDIP SID. Each sample tick, it walks SID #1 and, when enabled, SID #2 through a fixed job list: voice 1, voice 2, voice 3, filter, output. Each job is issued to the single datapath with a valid/ready handshake, and the scheduler waits for the datapath's completion pulse before issuing the next. It also generates the filter-state write enable and flags sample ticks lost to overrun.

## Interface
- NJOB, 5, jobs per SID (fixed). Job codes: 0 VOICE1, 1 VOICE2, 2 VOICE3, 3 FILTER, 4 OUTPUT.
- OVR_W, 8, width of the saturating overrun counter.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  sample strobe, one-cycle pulse.
- sid2_en  in  1  include SID #2 jobs. Sampled only when a tick is accepted.
- dp_ready  in  1  datapath accepts the presented job.
- dp_done  in  1  datapath finished the outstanding job, one-cycle pulse.
- clr_overrun  in  1  clears overrun and overrun_cnt.
- dp_valid  out  1  job presented to the datapath.
- dp_sid  out  1  SID index of the job (0 = SID #1).
- dp_op  out  3  job code.
- state_we  out  1  write enable for the filter_v_t state register of dp_sid.
- busy  out  1  sequence in progress.
- sample_done  out  1  one-cycle pulse when all jobs of the sample have completed.
- overrun  out  1  sticky flag: a tick arrived while busy.
- overrun_cnt  out  OVR_W  count of dropped ticks, saturating.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - tick → ISSUE; job = (sid 0, op 0); latch sid2_en into sid2_q.
  - No tick → stay in IDLE.
- ISSUE:
  - dp_valid = 1, with dp_sid and dp_op held stable.
  - dp_valid & dp_ready → WAIT. Otherwise stay in ISSUE, with no timeout.
- WAIT:
  - dp_valid = 0. Wait for dp_done.
  - dp_done ignored in IDLE and ISSUE: no state change, no state_we.
- On dp_done in WAIT:
  - op < 4 → op+1, go to ISSUE.
  - op == 4, sid 0 and sid2_q → sid 1, op 0, go to ISSUE.
  - Otherwise → IDLE, and sample_done pulses in the next cycle.
- state_we = (state == WAIT) & dp_done & (dp_op == 3). Combinational, same cycle as dp_done. dp_sid is valid in that cycle.
- busy = (state != IDLE).
- Overrun (tick while busy):
  - Tick is dropped; the sequence is unaffected.
  - overrun set to 1; overrun_cnt incremented, saturating at 2^OVR_W-1.
- Simultaneous events:
  - Tick in the same cycle as the final dp_done: counts as overrun, and is dropped.
  - Tick in the sample_done cycle (state is IDLE): accepted normally.
  - clr_overrun with an overrun tick in the same cycle: clear wins, so flag = 0 and count = 0.
- sid2_en toggling mid-sequence has no effect until the next accepted tick.
- Reset mid-operation: the FSM returns to IDLE immediately, and any outstanding datapath job is abandoned. The datapath is reset by the same rst.

## Timing
- Reset values: dp_valid 0, dp_sid 0, dp_op 0, state_we 0, busy 0, sample_done 0, overrun 0, overrun_cnt 0. FSM = IDLE.
- Tick at cycle t → dp_valid = 1 at t+1.
- Job accepted at cycle a → WAIT from a+1. Earliest dp_done is at a+1. Next dp_valid is at the cycle after dp_done.
- Minimum of 2 cycles per job, with dp_ready tied to 1 and dp_done returned one cycle after acceptance.
- Sample length with single-cycle datapath latency:
  - sid2_en = 1: 10 jobs. Final dp_done at t+20, sample_done at t+21.
  - sid2_en = 0: 5 jobs. Final dp_done at t+10, sample_done at t+11.
- All outputs registered except state_we and dp_valid. dp_valid is decoded from registered state.

## Test plan
- Reset, then tick with sid2_en = 1, dp_ready = 1, dp_done one cycle after acceptance:
  - Jobs (0,0..4) then (1,0..4) in order.
  - state_we exactly at the two FILTER completions.
  - sample_done at t+21; busy high from t+1 to t+20.
- sid2_en = 0: 5 jobs, all with dp_sid = 0; sample_done at t+11. Toggling sid2_en to 1 mid-sequence adds no jobs.
- Backpressure and latency:
  - dp_ready held low for 3 cycles on job (0,2): dp_valid and job fields stable, no advance.
  - Spurious dp_done during ISSUE ignored.
  - dp_done delayed 7 cycles: the scheduler waits.
- Overrun:
  - Ticks at t+5 and t+20 of a 10-job sample: overrun = 1, overrun_cnt = 2, sequence intact.
  - Tick in the sample_done cycle starts a new sequence.
  - clr_overrun together with a tick-while-busy: count = 0.
- Saturation: 300 overrun ticks → overrun_cnt = 255.
- Asynchronous rst asserted mid-WAIT on a FILTER job: all outputs go to reset values without a clock edge. A later dp_done produces no state_we. The next tick restarts at (0,0).
